// File: rtl/wb_queue.sv
// Writeback queue: merges ALU and LSU results into an in-order FIFO, drains one entry per
// cycle into the register file write port, and answers pending-write hazard queries.
module wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [4:0]                   alu_rd,
    input  logic [XLEN-1:0]              alu_data,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [4:0]                   lsu_rd,
    input  logic [XLEN-1:0]              lsu_data,
    output logic                         rf_we,
    output logic [4:0]                   rf_rd,
    output logic [XLEN-1:0]              rf_wdata,
    input  logic [4:0]                   q_rs1,
    input  logic [4:0]                   q_rs2,
    output logic                         q_hit1,
    output logic                         q_hit2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DepthCnt  = CW'(DEPTH);
    localparam logic [PW-1:0] LastPtr   = PW'(DEPTH - 1);
    localparam logic [PW:0]   DepthWrap = (PW + 1)'(DEPTH);

    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW-1:0]   alu_slot;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   free;
    logic            rf_we_q;
    logic [4:0]      rf_rd_q;
    logic [XLEN-1:0] rf_wdata_q;

    logic            lsu_push, alu_push, pop;
    logic [DEPTH-1:0] occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Readiness looks only at the registered count; a same-cycle pop never frees a slot.
    always_comb begin
        free      = DepthCnt - count_q;
        lsu_ready = (free != '0);
        alu_ready = (free >= CW'(2)) | ((free == CW'(1)) & ~lsu_valid);
    end

    always_comb begin
        lsu_push = lsu_valid & lsu_ready & (lsu_rd != 5'd0);
        alu_push = alu_valid & alu_ready & (alu_rd != 5'd0);
        pop      = (count_q != '0);
        alu_slot = lsu_push ? ptr_inc(tail_q) : tail_q;
        tail_d   = alu_push ? ptr_inc(alu_slot) : alu_slot;
        head_d   = pop ? ptr_inc(head_q) : head_q;
        count_d  = count_q + CW'(lsu_push) + CW'(alu_push) - CW'(pop);
    end

    // Storage needs no reset: occupancy is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (lsu_push) begin
            mem_rd[tail_q]   <= lsu_rd;
            mem_data[tail_q] <= lsu_data;
        end
        if (alu_push) begin
            mem_rd[alu_slot]   <= alu_rd;
            mem_data[alu_slot] <= alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rf_we_q <= pop;
            if (pop) begin
                rf_rd_q    <= mem_rd[head_q];
                rf_wdata_q <= mem_data[head_q];
            end
        end
    end

    // Mark the count_q slots starting at head as occupied, wrapping modulo DEPTH.
    always_comb begin
        logic [PW:0] idx;
        occ = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = {1'b0, head_q} + (PW + 1)'(k);
            if (idx >= DepthWrap) begin
                idx = idx - DepthWrap;
            end
            occ[idx[PW-1:0]] = (CW'(k) < count_q);
        end
    end

    always_comb begin
        q_hit1 = rf_we_q & (rf_rd_q == q_rs1);
        q_hit2 = rf_we_q & (rf_rd_q == q_rs2);
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && (mem_rd[i] == q_rs1)) begin
                q_hit1 = 1'b1;
            end
            if (occ[i] && (mem_rd[i] == q_rs2)) begin
                q_hit2 = 1'b1;
            end
        end
        q_hit1 = q_hit1 & (q_rs1 != 5'd0);
        q_hit2 = q_hit2 & (q_rs2 != 5'd0);
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign count    = count_q;

endmodule
